// File: rtl/stream_mac_v2.sv
// stream_mac_v2: AXIS read-data multiply-accumulate for bandwidth testing.
// Each accepted beat is split into DATA_WIDTH/LANE_W elements. The elements are summed,
// or their squares are summed, as signed or unsigned values, into an ACC_W accumulator.
// After a programmed number of beats the block reports done with the result and a sticky
// overflow flag.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   start_i, abort_i     run control pulses (abort wins when both are high)
//   nbeats_i, mode_i,    run configuration, latched when a start is accepted
//   is_signed_i
//   s_axis_*             AXI-Stream beat input; tready is registered
//   result_o, overflow_o accumulator value and sticky overflow flag
//   busy_o, done_o       busy is high in RUN/DRAIN; done is high in DONE
//   beat_cnt_o           beats accepted in the current run
module stream_mac_v2 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LANE_W     = 8,
  parameter int unsigned ACC_W      = 48,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_W-1:0]      nbeats_i,
  input  logic                  mode_i,
  input  logic                  is_signed_i,
  input  logic                  s_axis_tvalid_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic                  s_axis_tready_o,
  output logic [ACC_W-1:0]      result_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      beat_cnt_o
);

  localparam int unsigned Lanes = DATA_WIDTH / LANE_W;
  localparam int unsigned ExtW  = LANE_W + 1;  // one extra bit carries sign or zero
  localparam int unsigned SqW   = 2 * LANE_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    tready_q, tready_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        nbeats_q, nbeats_d;
  logic                    mode_q, mode_d;
  logic                    signed_q, signed_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  logic signed [ExtW-1:0]  s1_lane_q [Lanes];
  logic signed [ExtW-1:0]  s1_lane_d [Lanes];
  logic                    s1_vld_q, s1_vld_d;
  logic [ACC_W-1:0]        s2_sum_q, s2_sum_d;
  logic                    s2_vld_q, s2_vld_d;

  logic                    accept;
  logic                    start_ok;
  logic [ACC_W-1:0]        add_sum;
  logic                    add_carry;
  logic                    add_ovf;

  // tready_q is only ever high in RUN, so it already qualifies the handshake.
  assign accept   = s_axis_tvalid_i & tready_q;
  assign start_ok = start_i & ~abort_i & ((state_q == StIdle) | (state_q == StDone));

  // Control FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbeats_d = nbeats_q;
    mode_d   = mode_q;
    signed_d = signed_q;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_d  = StRun;
            cnt_d    = '0;
            nbeats_d = nbeats_i;
            mode_d   = mode_i;
            signed_d = is_signed_i;
          end
        end
        StRun: begin
          if (accept) cnt_d = cnt_q + CNT_W'(1);
          // Also covers nbeats=0: RUN lasts a single cycle.
          if (cnt_d >= nbeats_q) state_d = StDrain;
        end
        StDrain: begin
          // S1 empty means the last S2 sum lands in the accumulator on this edge.
          if (!s1_vld_q) state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
    tready_d = (state_d == StRun) && (cnt_d < nbeats_d);
  end

  // S1: split the beat into lanes and extend each by one bit
  always_comb begin
    s1_vld_d = accept & ~abort_i;
    for (int unsigned i = 0; i < Lanes; i++) begin
      s1_lane_d[i] = {signed_q & s_axis_tdata_i[i*LANE_W + LANE_W - 1],
                      s_axis_tdata_i[i*LANE_W +: LANE_W]};
    end
  end

  // S2: optional square, then sum the lanes modulo 2^ACC_W
  always_comb begin
    logic [SqW-1:0]   sq;
    logic [ACC_W-1:0] term;
    s2_vld_d = s1_vld_q & ~abort_i;
    s2_sum_d = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      // A square is never negative and fits in SqW bits, so it is zero-extended.
      sq = SqW'(s1_lane_q[i] * s1_lane_q[i]);
      if (mode_q) begin
        term = ACC_W'(sq);
      end else begin
        term = {{(ACC_W-ExtW){s1_lane_q[i][ExtW-1]}}, s1_lane_q[i]};
      end
      s2_sum_d = s2_sum_d + term;
    end
  end

  // S3: accumulate and track overflow
  always_comb begin
    {add_carry, add_sum} = {1'b0, acc_q} + {1'b0, s2_sum_q};
    if (signed_q) begin
      add_ovf = (acc_q[ACC_W-1] == s2_sum_q[ACC_W-1]) && (add_sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      add_ovf = add_carry;
    end
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (start_ok) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (s2_vld_q && !abort_i) begin
      acc_d = add_sum;
      ovf_d = ovf_q | add_ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      tready_q <= 1'b0;
      cnt_q    <= '0;
      nbeats_q <= '0;
      mode_q   <= 1'b0;
      signed_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_sum_q <= '0;
      for (int unsigned i = 0; i < Lanes; i++) s1_lane_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      cnt_q    <= cnt_d;
      nbeats_q <= nbeats_d;
      mode_q   <= mode_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (accept)   s1_lane_q <= s1_lane_d;
      if (s1_vld_q) s2_sum_q  <= s2_sum_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign result_o        = acc_q;
  assign overflow_o      = ovf_q;
  assign busy_o          = (state_q == StRun) | (state_q == StDrain);
  assign done_o          = (state_q == StDone);
  assign beat_cnt_o      = cnt_q;

endmodule

// File: tb/tb_stream_mac_v2.sv
// Directed bench for stream_mac_v2. Two instances share every input: the default
// 48-bit accumulator and a 16-bit accumulator used for wrap/overflow cases.
module tb_stream_mac_v2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] nbeats = '0;
  logic        mode = 1'b0;
  logic        is_signed = 1'b0;
  logic        tvalid = 1'b0;
  logic [63:0] tdata = '0;

  logic        tready, ovf48, busy, done;
  logic [47:0] r48;
  logic [31:0] bcnt;
  logic        tready16, ovf16, busy16, done16;
  logic [15:0] r16;
  logic [31:0] bcnt16;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_mac_v2 dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort), .nbeats_i(nbeats),
    .mode_i(mode), .is_signed_i(is_signed), .s_axis_tvalid_i(tvalid), .s_axis_tdata_i(tdata),
    .s_axis_tready_o(tready), .result_o(r48), .overflow_o(ovf48), .busy_o(busy),
    .done_o(done), .beat_cnt_o(bcnt)
  );

  stream_mac_v2 #(.ACC_W(16)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort), .nbeats_i(nbeats),
    .mode_i(mode), .is_signed_i(is_signed), .s_axis_tvalid_i(tvalid), .s_axis_tdata_i(tdata),
    .s_axis_tready_o(tready16), .result_o(r16), .overflow_o(ovf16), .busy_o(busy16),
    .done_o(done16), .beat_cnt_o(bcnt16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input logic m, input logic s);
    start = 1'b1; nbeats = n; mode = m; is_signed = s;
    tick();
    start = 1'b0;
  endtask

  // Drives beats until n have been accepted; returns just after the last accepting edge.
  task automatic send_beats(input int n, input logic [63:0] d, input bit gaps, output int got);
    got = 0;
    for (int i = 0; i < 400 && got < n; i++) begin
      tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      tdata  = d;
      if (tvalid && tready) got++;
      tick();
    end
    tvalid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin cyc = i; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    checks++; if ({tready, ovf48, busy, done} !== 4'b0)
      begin errs++; $display("FAIL reset_flags: got %b want 0000", {tready, ovf48, busy, done}); end
    checks++; if (r48 !== 48'd0 || bcnt !== 32'd0)
      begin errs++; $display("FAIL reset_values: result %0d cnt %0d want 0 0", r48, bcnt); end
    rstn = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || tready !== 1'b0)
      begin errs++; $display("FAIL reset_idle: busy %b tready %b want 0 0", busy, tready); end
  endtask

  task automatic test_unsigned_sum();
    int got;
    do_start(4, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || tready !== 1'b1 || bcnt !== 32'd0)
      begin errs++; $display("FAIL t1_run: busy %b tready %b cnt %0d want 1 1 0", busy, tready, bcnt); end
    send_beats(4, {8{8'h01}}, 1'b0, got);
    checks++; if (got !== 4 || bcnt !== 32'd4)
      begin errs++; $display("FAIL t1_accepts: got %0d cnt %0d want 4 4", got, bcnt); end
    checks++; if (tready !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
      begin errs++; $display("FAIL t1_drain: tready %b done %b busy %b want 0 0 1", tready, done, busy); end
    tick();
    checks++; if (done !== 1'b0)
      begin errs++; $display("FAIL t1_done_early: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL t1_done_timing: done %b busy %b want 1 0", done, busy); end
    checks++; if (r48 !== 48'd32 || ovf48 !== 1'b0)
      begin errs++; $display("FAIL t1_result: got %0d ovf %b want 32 0", r48, ovf48); end
  endtask

  task automatic test_signed_sum();
    int got, cyc;
    do_start(2, 1'b0, 1'b1);
    send_beats(2, {8{8'hFF}}, 1'b1, got);
    wait_done(cyc);
    checks++; if (cyc < 0)
      begin errs++; $display("FAIL t2_timeout: done %b want 1", done); end
    checks++; if (r48 !== 48'hFFFF_FFFF_FFF0 || ovf48 !== 1'b0)
      begin errs++; $display("FAIL t2_result48: got %h ovf %b want fffffffffff0 0", r48, ovf48); end
    checks++; if (r16 !== 16'hFFF0 || ovf16 !== 1'b0)
      begin errs++; $display("FAIL t2_result16: got %h ovf %b want fff0 0", r16, ovf16); end
  endtask

  task automatic test_squares();
    int got, cyc;
    do_start(1, 1'b1, 1'b1);
    send_beats(1, {8{8'h80}}, 1'b0, got);
    wait_done(cyc);
    checks++; if (cyc < 0 || r48 !== 48'd131072 || ovf48 !== 1'b0)
      begin errs++; $display("FAIL t3_signed_sq: got %0d ovf %b want 131072 0", r48, ovf48); end
    do_start(1, 1'b1, 1'b0);
    send_beats(1, {8{8'h80}}, 1'b0, got);
    wait_done(cyc);
    checks++; if (cyc < 0 || r48 !== 48'd131072 || ovf48 !== 1'b0)
      begin errs++; $display("FAIL t3_unsigned_sq: got %0d ovf %b want 131072 0", r48, ovf48); end
  endtask

  task automatic test_wrap();
    int got, cyc;
    do_start(33, 1'b0, 1'b0);
    send_beats(33, {8{8'hFF}}, 1'b0, got);
    wait_done(cyc);
    checks++; if (cyc < 0 || bcnt !== 32'd33)
      begin errs++; $display("FAIL t4_cnt: got %0d done %b want 33 1", bcnt, done); end
    checks++; if (r16 !== 16'd1784 || ovf16 !== 1'b1)
      begin errs++; $display("FAIL t4_wrap16: got %0d ovf %b want 1784 1", r16, ovf16); end
    checks++; if (r48 !== 48'd67320 || ovf48 !== 1'b0)
      begin errs++; $display("FAIL t4_wide48: got %0d ovf %b want 67320 0", r48, ovf48); end
  endtask

  task automatic test_zero_beats();
    int cyc;
    bit seen = 1'b0;
    do_start(0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || tready !== 1'b0)
      begin errs++; $display("FAIL t5_run: busy %b tready %b want 1 0", busy, tready); end
    // A start in RUN must not relaunch with the new count.
    start = 1'b1; nbeats = 5;
    tick();
    start = 1'b0;
    tvalid = 1'b1; tdata = {8{8'h01}};
    cyc = -1;
    for (int i = 0; i < 10; i++) begin
      if (tready) seen = 1'b1;
      if (done) begin cyc = i; break; end
      tick();
    end
    tvalid = 1'b0;
    checks++; if (cyc < 0 || seen)
      begin errs++; $display("FAIL t5_no_accept: done %b tready_seen %b want 1 0", done, seen); end
    checks++; if (r48 !== 48'd0 || bcnt !== 32'd0)
      begin errs++; $display("FAIL t5_result: got %0d cnt %0d want 0 0", r48, bcnt); end
  endtask

  task automatic test_abort();
    int got, cyc;
    logic [47:0] held;
    do_start(10, 1'b0, 1'b0);
    send_beats(5, {8{8'h01}}, 1'b1, got);
    abort = 1'b1; tvalid = 1'b1;
    tick();
    abort = 1'b0; tvalid = 1'b0;
    checks++; if ({busy, done, tready} !== 3'b000 || bcnt !== 32'd5)
      begin errs++; $display("FAIL t6_abort: bdt %b cnt %0d want 000 5", {busy, done, tready}, bcnt); end
    held = r48;
    tick(); tick(); tick();
    checks++; if (r48 !== held || bcnt !== 32'd5)
      begin errs++; $display("FAIL t6_flushed: got %0d cnt %0d want %0d 5", r48, bcnt, held); end
    start = 1'b1; abort = 1'b1; nbeats = 3;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0)
      begin errs++; $display("FAIL t6_abort_wins: busy %b want 0", busy); end
    do_start(3, 1'b0, 1'b0);
    send_beats(3, {8{8'h02}}, 1'b1, got);
    wait_done(cyc);
    checks++; if (cyc < 0 || r48 !== 48'd48 || bcnt !== 32'd3)
      begin errs++; $display("FAIL t6_restart: got %0d cnt %0d done %b want 48 3 1", r48, bcnt, done); end
  endtask

  task automatic test_reset_mid_run();
    int got;
    do_start(4, 1'b0, 1'b0);
    send_beats(2, {8{8'h01}}, 1'b0, got);
    #2 rstn = 1'b0;
    #1;
    checks++; if ({busy, done, tready, ovf48} !== 4'b0 || r48 !== 48'd0 || bcnt !== 32'd0)
      begin errs++; $display("FAIL t7_async_reset: flags %b result %0d cnt %0d want 0 0 0",
                             {busy, done, tready, ovf48}, r48, bcnt); end
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || r48 !== 48'd0)
      begin errs++; $display("FAIL t7_after_reset: busy %b result %0d want 0 0", busy, r48); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_unsigned_sum();
    test_signed_sum();
    test_squares();
    test_wrap();
    test_zero_beats();
    test_abort();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
